// File: rtl/tdc_interval_averager.sv
// Turns TDC (int_part, frac_part) strobes into fixed-point samples and reports
// mean/min/max over windows of 2^LOG2_N accepted samples on a valid/ready port.
module tdc_interval_averager #(
    parameter int FRAC_SHIFT = 10,
    parameter int LOG2_N     = 2,
    parameter int SAMPLE_W   = 12 + FRAC_SHIFT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [10:0]         frac_part,
    input  logic [10:0]         int_part,
    input  logic                wrena,
    output logic [SAMPLE_W-1:0] out_mean,
    output logic [SAMPLE_W-1:0] out_min,
    output logic [SAMPLE_W-1:0] out_max,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun,
    output logic [15:0]         reject_cnt
);
    localparam int ACC_W = SAMPLE_W + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam int N     = 1 << LOG2_N;

    typedef enum logic {IDLE, ACCUM} state_t;
    state_t state, state_next;

    logic                s1_valid;
    logic [SAMPLE_W-1:0] s1_sample;
    logic [SAMPLE_W-1:0] sample_in;
    logic                bad_int;

    logic [ACC_W-1:0]    acc, acc_sum;
    logic [CNT_W-1:0]    count;
    logic [SAMPLE_W-1:0] min_r, max_r, min_nx, max_nx;
    logic                take, complete, load;

    assign sample_in = (SAMPLE_W'(int_part) << FRAC_SHIFT) + SAMPLE_W'(frac_part);
    // all-ones count means the upstream count-1 underflowed
    assign bad_int   = (int_part == 11'h7FF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en)  state_next = ACCUM;
            ACCUM:   if (!en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        take     = (state == ACCUM) && en && s1_valid;
        complete = take && (count == CNT_W'(N - 1));
        load     = complete && (!out_valid || out_ready);
        acc_sum  = acc + ACC_W'(s1_sample);
        min_nx   = (s1_sample < min_r) ? s1_sample : min_r;
        max_nx   = (s1_sample > max_r) ? s1_sample : max_r;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid   <= 1'b0;
            s1_sample  <= '0;
            reject_cnt <= '0;
        end else begin
            s1_valid  <= en && wrena && !bad_int;
            s1_sample <= sample_in;
            if (en && wrena && bad_int && reject_cnt != 16'hFFFF)
                reject_cnt <= reject_cnt + 16'd1;
        end
    end

    // completing window restarts from reset values so the next sample opens a new one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            count <= '0;
            min_r <= '1;
            max_r <= '0;
        end else if (!en || complete) begin
            acc   <= '0;
            count <= '0;
            min_r <= '1;
            max_r <= '0;
        end else if (take) begin
            acc   <= acc_sum;
            count <= count + CNT_W'(1);
            min_r <= min_nx;
            max_r <= max_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_mean  <= '0;
            out_min   <= '0;
            out_max   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                out_mean <= SAMPLE_W'(acc_sum >> LOG2_N);
                out_min  <= min_nx;
                out_max  <= max_nx;
            end
            if (load)           out_valid <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;
            if (!en)                    overrun <= 1'b0;
            else if (complete && !load) overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tdc_interval_averager.sv
// Randomized and directed checks of tdc_interval_averager against a queue-based window model.
module tb_tdc_interval_averager;
    localparam int FRAC_SHIFT = 10;
    localparam int LOG2_N     = 2;
    localparam int SAMPLE_W   = 12 + FRAC_SHIFT;
    localparam int N          = 1 << LOG2_N;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0, wrena = 1'b0, out_ready = 1'b0;
    logic [10:0] frac_part = '0, int_part = '0;
    logic [SAMPLE_W-1:0] out_mean, out_min, out_max;
    logic out_valid, overrun;
    logic [15:0] reject_cnt;

    int nvec = 0;
    int nerr = 0;

    tdc_interval_averager #(.FRAC_SHIFT(FRAC_SHIFT), .LOG2_N(LOG2_N)) dut (
        .clk(clk), .rst(rst), .en(en), .frac_part(frac_part), .int_part(int_part),
        .wrena(wrena), .out_mean(out_mean), .out_min(out_min), .out_max(out_max),
        .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun),
        .reject_cnt(reject_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a sample enters the window one edge after its strobe; the window
    // is summarised only once it holds N samples.
    longint win[$];
    logic   pend_v = 1'b0;
    longint pend_s = 0;
    longint m_mean = 0, m_min = 0, m_max = 0;
    logic   m_valid = 1'b0, m_ovr = 1'b0;
    longint m_rej = 0;

    function automatic longint win_mean();
        longint s = 0;
        foreach (win[i]) s += win[i];
        return s / N;
    endfunction
    function automatic longint win_min();
        longint m = (longint'(1) << SAMPLE_W) - 1;
        foreach (win[i]) if (win[i] < m) m = win[i];
        return m;
    endfunction
    function automatic longint win_max();
        longint m = 0;
        foreach (win[i]) if (win[i] > m) m = win[i];
        return m;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            win.delete();
            pend_v <= 1'b0; pend_s <= 0;
            m_mean <= 0; m_min <= 0; m_max <= 0;
            m_valid <= 1'b0; m_ovr <= 1'b0; m_rej <= 0;
        end else begin
            if (out_ready) m_valid <= 1'b0;
            if (!en) begin
                win.delete();
                m_ovr <= 1'b0;
            end else if (pend_v) begin
                win.push_back(pend_s);
                if (win.size() == N) begin
                    if (!m_valid || out_ready) begin
                        m_mean <= win_mean(); m_min <= win_min(); m_max <= win_max();
                        m_valid <= 1'b1;
                    end else begin
                        m_ovr <= 1'b1;
                    end
                    win.delete();
                end
            end
            pend_v <= en && wrena && (int_part != 11'h7FF);
            pend_s <= longint'(int_part) * (1 << FRAC_SHIFT) + longint'(frac_part);
            if (en && wrena && int_part == 11'h7FF && m_rej != 65535) m_rej <= m_rej + 1;
        end
    end

    always @(negedge clk) begin
        chk("out_valid", out_valid, m_valid);
        chk("out_mean", out_mean, m_mean);
        chk("out_min", out_min, m_min);
        chk("out_max", out_max, m_max);
        chk("overrun", overrun, m_ovr);
        chk("reject_cnt", reject_cnt, m_rej);
    end

    // accepted results, in order
    longint acc_mean[$], acc_min[$], acc_max[$];
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            acc_mean.push_back(out_mean);
            acc_min.push_back(out_min);
            acc_max.push_back(out_max);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic smp(input int i, input int f);
        wrena = 1'b1; int_part = 11'(i); frac_part = 11'(f);
        cyc();
        wrena = 1'b0;
    endtask

    task automatic clear_acc();
        acc_mean.delete(); acc_min.delete(); acc_max.delete();
    endtask

    initial begin
        cyc(); cyc();
        chk("rst_valid", out_valid, 0);
        chk("rst_mean", out_mean, 0);
        chk("rst_reject", reject_cnt, 0);
        rst = 1'b1;

        // basic window
        en = 1'b1; cyc();
        smp(3, 100); smp(3, 200); smp(3, 300); smp(3, 400);
        cyc();
        chk("basic_valid", out_valid, 1);
        chk("basic_mean", out_mean, 3322);
        chk("basic_min", out_min, 3172);
        chk("basic_max", out_max, 3472);
        cyc(); cyc();
        chk("basic_hold_valid", out_valid, 1);
        chk("basic_hold_mean", out_mean, 3322);
        out_ready = 1'b1; cyc();
        chk("basic_accept", out_valid, 0);
        out_ready = 1'b0;

        // rejection
        smp(3, 100); smp(2047, 5); smp(3, 200); smp(3, 300); smp(3, 400);
        cyc();
        chk("rej_cnt", reject_cnt, 1);
        chk("rej_valid", out_valid, 1);
        chk("rej_mean", out_mean, 3322);
        out_ready = 1'b1; cyc();

        // back-to-back
        clear_acc();
        for (int i = 0; i < 12; i++) begin
            wrena = (i < 8); int_part = 11'd1; frac_part = 11'(i);
            cyc();
        end
        wrena = 1'b0;
        chk("b2b_count", acc_mean.size(), 2);
        if (acc_mean.size() == 2) begin
            chk("b2b_mean0", acc_mean[0], 1025);
            chk("b2b_mean1", acc_mean[1], 1029);
            chk("b2b_min0", acc_min[0], 1024);
            chk("b2b_max0", acc_max[0], 1027);
            chk("b2b_min1", acc_min[1], 1028);
            chk("b2b_max1", acc_max[1], 1031);
        end
        chk("b2b_overrun", overrun, 0);

        // overrun
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) smp(2, 0);
        cyc(); cyc();
        chk("ovr_mean", out_mean, 2048);
        chk("ovr_valid", out_valid, 1);
        chk("ovr_flag", overrun, 1);
        en = 1'b0; cyc(); cyc();
        chk("ovr_cleared", overrun, 0);
        chk("ovr_still_valid", out_valid, 1);
        out_ready = 1'b1; cyc();
        chk("ovr_accept", out_valid, 0);

        // enable drop
        en = 1'b1; cyc();
        smp(7, 1); smp(7, 1);
        en = 1'b0; cyc(); cyc(); cyc();
        en = 1'b1; clear_acc();
        for (int i = 0; i < 4; i++) smp(5, 8);
        cyc(); cyc(); cyc();
        chk("endrop_count", acc_mean.size(), 1);
        if (acc_mean.size() == 1) chk("endrop_mean", acc_mean[0], 5128);

        // reset mid-window
        smp(2047, 0);
        smp(4, 9); smp(4, 9); smp(4, 9);
        @(negedge clk); #2;
        rst = 1'b0; #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_mean", out_mean, 0);
        chk("mrst_reject", reject_cnt, 0);
        chk("mrst_overrun", overrun, 0);
        #1 rst = 1'b1;
        clear_acc();
        for (int i = 0; i < 4; i++) smp(4, i);
        cyc(); cyc(); cyc();
        chk("mrst_count", acc_mean.size(), 1);
        if (acc_mean.size() == 1) chk("mrst_mean_after", acc_mean[0], 4097);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            en        = ($urandom_range(0, 15) != 0);
            wrena     = ($urandom_range(0, 3) != 0);
            int_part  = ($urandom_range(0, 7) == 0) ? 11'h7FF : 11'($urandom_range(0, 2046));
            frac_part = 11'($urandom_range(0, 2047));
            out_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/tdc_interval_averager.md
Name: tdc_interval_averager

Overview:
Consumes the interval stream from the TDC time counter (frac_part, int_part, wrena) and forms a fixed-point interval value per measurement. It accumulates 2^LOG2_N accepted samples into one window and emits the window mean, minimum and maximum through a valid/ready result port. The result port feeds the readout/host interface. Invalid samples are rejected, and output overruns are flagged.

Parameters:
FRAC_SHIFT, 10, weight of int_part in fixed-point units; sample = int_part*2^FRAC_SHIFT + frac_part
LOG2_N, 2, log2 of samples per window (N = 2^LOG2_N), legal 0..8
SAMPLE_W, 12+FRAC_SHIFT, width of one combined sample (derived, do not override)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous active-low reset
en  in  1  averaging enable; low = idle and clear window
frac_part  in  11  fractional code from time counter
int_part  in  11  integer period count from time counter
wrena  in  1  one-cycle strobe, frac_part/int_part valid
out_mean  out  SAMPLE_W  window mean (truncated)
out_min  out  SAMPLE_W  smallest sample in window
out_max  out  SAMPLE_W  largest sample in window
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
overrun  out  1  sticky: a completed window was dropped
reject_cnt  out  16  count of rejected samples, saturating

Behaviour:
- Reset (rst=0, async): all outputs 0, accumulator 0, sample count 0, min register all-ones, max register 0, state IDLE.
- Stage 1 (input): on an edge with wrena=1 and en=1, register sample = {int_part, FRAC_SHIFT'b0} + frac_part, zero-extended to SAMPLE_W, plus a valid bit. wrena=0 or en=0 -> valid bit 0.
- Rejection: int_part == 11'h7FF (upstream underflow of count-1) -> sample not registered as valid; reject_cnt += 1, saturating at 16'hFFFF. Rejection is evaluated in stage 1 and only when en=1.
- FSM states: IDLE, ACCUM.
  - IDLE: en=0. The accumulator, count, min and max are held at their reset values. reject_cnt is held. overrun is cleared.
  - IDLE -> ACCUM: en=1.
  - ACCUM -> IDLE: en=0. The partial window is discarded. A pending out_valid result is kept until it is accepted.
- Stage 2 (accumulate, ACCUM only): on a valid stage-1 sample:
  - acc += sample; acc width is SAMPLE_W+LOG2_N, so no overflow is possible.
  - min = min(min, sample); max = max(max, sample).
  - count += 1.
- Window completion: when the sample being accumulated is the Nth, on that same edge:
  - result regs <= ((acc+sample) >> LOG2_N, final min, final max);
  - acc, count, min, max return to their reset values.
  - The next sample starts a new window with no gap.
- Latency: wrena on edge t -> accumulated on edge t+1. For the Nth sample, out_valid=1 after edge t+1, i.e. 2 cycles after wrena.
- Handshake: out_valid rises when a result loads. It falls on an edge where out_valid && out_ready and no new result loads. Results are stable while out_valid=1 && out_ready=0.
- Simultaneous accept and new completion on the same edge: the new result loads and out_valid stays 1.
- Completion while out_valid=1 && out_ready=0: the new result is dropped, the old result is held, and overrun <= 1.
- wrena strobes may arrive every cycle; full throughput is 1 sample/clk.
- LOG2_N=0: every accepted sample is its own result; mean = min = max = sample.
- Reset asserted mid-window: immediate return to the reset state; the partial window is lost.

Test Plan:
- Basic window (FRAC_SHIFT=10, LOG2_N=2): en=1, four wrena pulses with int=3, frac=100/200/300/400 -> 2 cycles after the last wrena: out_valid=1, mean=3322, min=3172, max=3472; hold with out_ready=0, then assert it -> out_valid=0 next cycle.
- Rejection: a window containing one int=2047 strobe among five -> reject_cnt=1; the result uses only the four valid samples (values as in the basic window).
- Back-to-back: 8 consecutive-cycle wrena, int=1, frac=0..7, out_ready=1 -> two results, mean 1025 then 1029, min/max 1024/1027 and 1028/1031; overrun=0.
- Overrun: out_ready=0, 8 samples all int=2, frac=0 -> first result mean=2048 held, overrun=1. Then en=0 -> overrun=0, and the result is still valid until it is accepted.
- Enable drop: 2 samples, en=0 for 3 cycles, en=1, then 4 samples of int=5, frac=8 -> exactly one result, mean=5128.
- Reset mid-window: 3 samples, pulse rst low asynchronously between edges -> all outputs 0 immediately; the next 4 samples produce a correct mean unaffected by the earlier 3.
